// File: rtl/gpio_apb_n.sv
// GPIO block with an APB slave port: per-pin enable/direction, set/clear
// output register, synchronised inputs and edge-triggered interrupts.
module gpio_apb_n #(
    parameter int NPINS       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [7:0]       PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oe,
    output logic             irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t r_state, w_state_nxt;
    logic   r_perr;   // ACCESS was entered straight from IDLE

    logic [NPINS-1:0] r_psl, r_dir, r_out, r_in, r_rise, r_fall, r_istat;
    logic [NPINS-1:0] r_hist;
    logic [SYNC_STAGES-1:0][NPINS-1:0] r_sync;
    logic             r_irq;

    logic [2:0]       w_idx;
    logic             w_unmapped, w_access, w_err, w_wr;
    logic [7:0]       w_wen;
    logic [NPINS-1:0] w_wdata, w_en, w_sync, w_in, w_rise, w_fall, w_istat_nxt;
    logic [NPINS-1:0] w_rsel;
    logic             w_unused;

    // APB phase register and protocol-violation flag
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_perr  <= (r_state == ST_IDLE) && PSEL && PENABLE;
        end
    end

    // APB phase next-state; PSEL&PENABLE from IDLE still lands in ACCESS so it can error out
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (PSEL) w_state_nxt = PENABLE ? ST_ACCESS : ST_SETUP;
            ST_SETUP:  if (!PSEL) w_state_nxt = ST_IDLE;
                       else if (PENABLE) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = (PSEL && !PENABLE) ? ST_SETUP : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_idx      = PADDR[4:2];
    assign w_unmapped = |PADDR[7:5];
    assign w_access   = (r_state == ST_ACCESS);
    assign w_err      = w_access && (r_perr || w_unmapped || (PWRITE && w_idx == 3'd4));
    assign w_wr       = w_access && PWRITE && !w_err;
    assign w_wen      = w_wr ? (8'd1 << w_idx) : 8'd0;
    assign w_wdata    = PWDATA[NPINS-1:0];
    assign w_unused   = ^{PADDR[1:0], PWDATA};

    // Input path: IN tracks the synchroniser while the pin is an enabled input,
    // and is read through combinationally so the visible latency is the chain depth.
    assign w_en        = r_psl & ~r_dir;
    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_in        = (w_en & w_sync) | (~w_en & r_in);
    assign w_rise      = w_en & r_rise & w_sync & ~r_hist;
    assign w_fall      = w_en & r_fall & ~w_sync & r_hist;
    // New edges are OR'd in after the W1C mask so they win a same-cycle clear
    assign w_istat_nxt = (r_istat & ~(w_wen[7] ? w_wdata : '0)) | w_rise | w_fall;

    // Register file, synchroniser, edge history and interrupt flop
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_psl   <= '0;
            r_dir   <= '0;
            r_out   <= '0;
            r_in    <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_istat <= '0;
            r_hist  <= '0;
            r_sync  <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wen[0]) r_psl  <= w_wdata;
            if (w_wen[1]) r_dir  <= w_wdata;
            if (w_wen[2]) r_out  <= r_out | w_wdata;
            if (w_wen[3]) r_out  <= r_out & ~w_wdata;
            if (w_wen[5]) r_rise <= w_wdata;
            if (w_wen[6]) r_fall <= w_wdata;
            r_istat <= w_istat_nxt;
            r_in    <= w_in;
            r_hist  <= w_sync;
            r_sync  <= {r_sync[SYNC_STAGES-2:0], gpio_in};
            r_irq   <= |r_istat;
        end
    end

    // Read mux; data only appears during an error-free read in ACCESS
    always_comb begin
        w_rsel = '0;
        case (w_idx)
            3'd0: w_rsel = r_psl;
            3'd1: w_rsel = r_dir;
            3'd2: w_rsel = r_out;
            3'd3: w_rsel = r_out;
            3'd4: w_rsel = w_in;
            3'd5: w_rsel = r_rise;
            3'd6: w_rsel = r_fall;
            3'd7: w_rsel = r_istat;
            default: w_rsel = '0;
        endcase
        PRDATA = '0;
        if (w_access && !PWRITE && !w_err) PRDATA[NPINS-1:0] = w_rsel;
    end

    assign PREADY   = w_access;
    assign PSLVERR  = w_err;
    assign gpio_oe  = r_psl & r_dir;
    assign gpio_out = r_out & gpio_oe;
    assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_apb_n.sv
// Randomised bench for gpio_apb_n against a transaction-level register model.
module tb_gpio_apb_n;

    localparam int NPINS = 8;
    localparam int S     = 2;
    localparam logic [31:0] MASK = (NPINS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NPINS) - 32'd1);

    logic PCLK, PRESETn, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic PREADY, PSLVERR, irq;
    logic [NPINS-1:0] gpio_in, gpio_out, gpio_oe;

    int n_chk, n_fail;

    // model state, all masked to NPINS bits
    logic [31:0] m_psl, m_dir, m_out, m_in, m_rise, m_fall, m_istat, m_hist;

    gpio_apb_n #(.NPINS(NPINS), .SYNC_STAGES(S)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [7:0] addr);
        if (addr[7:5] != 3'd0) return 32'd0;
        case (addr[4:2])
            3'd0: return m_psl;
            3'd1: return m_dir;
            3'd2, 3'd3: return m_out;
            3'd4: return m_in;
            3'd5: return m_rise;
            3'd6: return m_fall;
            default: return m_istat;
        endcase
    endfunction

    function automatic logic [31:0] g32();
        return 32'(gpio_in);
    endfunction

    // enabled inputs show the (settled) pad value; others hold
    task automatic model_in_refresh();
        logic [31:0] en;
        en   = m_psl & ~m_dir;
        m_in = (m_in & ~en) | (g32() & en);
    endtask

    task automatic model_reset();
        m_psl = 0; m_dir = 0; m_out = 0; m_in = 0;
        m_rise = 0; m_fall = 0; m_istat = 0; m_hist = 0;
    endtask

    task automatic check_pins();
        check("gpio_oe",  32'(gpio_oe),  m_psl & m_dir);
        check("gpio_out", 32'(gpio_out), m_out & m_psl & m_dir);
        check("irq",      32'(irq),      32'(|m_istat));
    endtask

    // drives SETUP now, ACCESS next, samples in ACCESS, returns after the commit edge
    task automatic apb_body(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err, output logic rdy);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        rd = PRDATA; err = PSLVERR; rdy = PREADY;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err, output logic rdy);
        @(negedge PCLK);
        apb_body(wr, addr, wd, rd, err, rdy);
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] d);
        logic [31:0] rd;
        logic err, rdy, exp_err;
        apb_xfer(1'b1, addr, d, rd, err, rdy);
        exp_err = (addr[7:5] != 3'd0) || (addr[4:2] == 3'd4);
        check("wr_pready",  32'(rdy), 32'd1);
        check("wr_pslverr", 32'(err), 32'(exp_err));
        if (!exp_err) begin
            case (addr[4:2])
                3'd0: m_psl   = d & MASK;
                3'd1: m_dir   = d & MASK;
                3'd2: m_out   = m_out | (d & MASK);
                3'd3: m_out   = m_out & ~d;
                3'd5: m_rise  = d & MASK;
                3'd6: m_fall  = d & MASK;
                3'd7: m_istat = m_istat & ~d;
                default: ;
            endcase
        end
        model_in_refresh();
        @(negedge PCLK);
        check_pins();
    endtask

    task automatic rd_reg(input logic [7:0] addr, input string tag);
        logic [31:0] rd;
        logic err, rdy;
        apb_xfer(1'b0, addr, 32'd0, rd, err, rdy);
        check(tag, rd, model_rd(addr));
        check("rd_pslverr", 32'(err), 32'(addr[7:5] != 3'd0));
        check("rd_pready",  32'(rdy), 32'd1);
    endtask

    // change the pads, let everything settle, then apply edge rules to the model
    task automatic gpio_set(input logic [NPINS-1:0] g);
        logic [31:0] en;
        @(negedge PCLK);
        gpio_in = g;
        repeat (S + 3) @(negedge PCLK);
        en      = m_psl & ~m_dir;
        m_istat = m_istat | (en & m_rise & g32() & ~m_hist) | (en & m_fall & ~g32() & m_hist);
        m_hist  = g32();
        model_in_refresh();
        check_pins();
    endtask

    initial begin
        logic [31:0] rd;
        logic err, rdy;
        logic [7:0] a;
        n_chk = 0; n_fail = 0;
        PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        gpio_in = '0;
        model_reset();
        repeat (3) @(negedge PCLK);
        check("rst_prdata",  PRDATA, 32'd0);
        check("rst_pready",  32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check_pins();
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        // output set/clear
        wr_reg(8'h00, 32'hFF);
        wr_reg(8'h04, 32'h0F);
        wr_reg(8'h08, 32'h05);
        wr_reg(8'h0C, 32'h01);
        check("oe_0F",  32'(gpio_oe),  32'h0F);
        check("out_04", 32'(gpio_out), 32'h04);
        rd_reg(8'h08, "rd_set");
        rd_reg(8'h0C, "rd_clr");

        // input path
        wr_reg(8'h04, 32'h00);
        gpio_set(NPINS'(8'hA5));
        rd_reg(8'h10, "rd_in_A5");
        check("in_A5_const", m_in, 32'hA5 & MASK);

        // rising-edge interrupt with latency
        wr_reg(8'h14, 32'h01);
        gpio_set(gpio_in & ~NPINS'(1));
        @(negedge PCLK);
        gpio_in[0] = 1'b1;
        repeat (S + 1) @(negedge PCLK);
        check("irq_early", 32'(irq), 32'd0);
        @(negedge PCLK);
        check("irq_latency", 32'(irq), 32'd1);
        m_istat = m_istat | 32'd1; m_hist = g32(); model_in_refresh();
        rd_reg(8'h1C, "rd_istat_rise");
        apb_xfer(1'b1, 8'h1C, 32'h01, rd, err, rdy);
        m_istat = m_istat & ~32'd1;
        check("irq_hold", 32'(irq), 32'd1);
        @(negedge PCLK);
        check("irq_clr", 32'(irq), 32'd0);

        // edge vs W1C in the same cycle
        wr_reg(8'h18, 32'h01);
        gpio_set(gpio_in & ~NPINS'(1));
        gpio_set(gpio_in | NPINS'(1));
        check("istat_pre", m_istat & 32'd1, 32'd1);
        @(negedge PCLK);
        gpio_in[0] = 1'b0;
        repeat (S - 2) @(negedge PCLK);
        apb_body(1'b1, 8'h1C, 32'h01, rd, err, rdy);
        m_istat = m_istat | 32'd1; m_hist = g32(); model_in_refresh();
        rd_reg(8'h1C, "rd_istat_collide");
        wr_reg(8'h1C, 32'h01);
        rd_reg(8'h1C, "rd_istat_cleared");

        // error responses
        wr_reg(8'h10, 32'h5A);
        rd_reg(8'h10, "rd_in_after_err");
        rd_reg(8'h40, "rd_unmapped");
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'hFF;
        @(negedge PCLK);
        check("proto_pready",  32'(PREADY),  32'd1);
        check("proto_pslverr", 32'(PSLVERR), 32'd1);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        rd_reg(8'h04, "rd_dir_after_proto");
        check_pins();

        // randomised traffic
        for (int i = 0; i < 250; i++) begin
            int op;
            op = $urandom_range(0, 9);
            a  = {3'(0), 5'd0};
            a  = 8'({6'($urandom_range(0, 9)), 2'($urandom)});
            if (op < 4)      wr_reg(a, $urandom);
            else if (op < 7) rd_reg(a, "rd_rand");
            else             gpio_set(NPINS'($urandom));
        end

        // reset in the middle of a DIR write
        wr_reg(8'h00, 32'hFF);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'hFF;
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        check("rst_mid_oe",     32'(gpio_oe), 32'd0);
        check("rst_mid_pready", 32'(PREADY),  32'd0);
        check("rst_mid_irq",    32'(irq),     32'd0);
        PSEL = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        model_reset();
        m_hist = g32();
        repeat (S + 3) @(negedge PCLK);
        check_pins();
        rd_reg(8'h04, "rd_dir_after_rst");
        rd_reg(8'h00, "rd_psl_after_rst");
        rd_reg(8'h1C, "rd_istat_after_rst");
        check("dir_zero_const", m_dir, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_apb_n.md
GPIO_APB_N -- requirements
Module: gpio_apb_n

Interface
REQ-001 SHALL have parameter NPINS, default 8, number of GPIO pins (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal 2..3).
REQ-003 SHALL have port PCLK, input, 1, sole clock; all flops on rising edge.
REQ-004 SHALL have port PRESETn, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port PSEL, input, 1, APB select.
REQ-006 SHALL have port PENABLE, input, 1, APB access phase.
REQ-007 SHALL have port PWRITE, input, 1, APB direction; 1 means write.
REQ-008 SHALL have port PADDR, input, 8, byte address; bits [1:0] ignored.
REQ-009 SHALL have port PWDATA, input, 32, write data.
REQ-010 SHALL have port PRDATA, output, 32, read data.
REQ-011 SHALL have port PREADY, output, 1, transfer complete.
REQ-012 SHALL have port PSLVERR, output, 1, transfer error.
REQ-013 SHALL have port gpio_in, input, NPINS, pad input values (asynchronous).
REQ-014 SHALL have port gpio_out, output, NPINS, pad output values.
REQ-015 SHALL have port gpio_oe, output, NPINS, pad output enables.
REQ-016 SHALL have port irq, output, 1, level interrupt.

Function
REQ-017 SHALL implement the register map as follows; the valid field is [NPINS-1:0], and higher bits read 0 and ignore writes:
- 0x00 PSL: pin enable, RW.
- 0x04 DIR: 1 means output, RW.
- 0x08 SET: writing 1 sets OUT bits; reads OUT.
- 0x0C CLR: writing 1 clears OUT bits; reads OUT.
- 0x10 IN: synchronised input, RO.
- 0x14 RISE_EN: RW.
- 0x18 FALL_EN: RW.
- 0x1C ISTAT: writing 1 clears a bit.
REQ-018 SHALL drive gpio_oe = PSL & DIR and gpio_out = OUT & gpio_oe.
REQ-019 SHALL track APB phase with a 3-state FSM:
- IDLE goes to SETUP on PSEL & !PENABLE.
- SETUP goes to ACCESS on PSEL & PENABLE.
- ACCESS goes to SETUP on PSEL & !PENABLE; otherwise it goes to IDLE.
- SETUP with !PSEL returns to IDLE.
REQ-020 SHALL assert PREADY in ACCESS only; this gives zero wait states.
REQ-021 SHALL commit writes only at the clock edge ending ACCESS.
REQ-022 SHALL drive PRDATA combinationally with the addressed register during a read in ACCESS, and drive 0 at all other times.
REQ-023 SHALL assert PSLVERR in ACCESS for any of the following, with no register change:
- an unmapped address;
- a write to IN;
- PSEL & PENABLE arriving directly from IDLE, which is a protocol violation; this case SHALL also move the FSM to ACCESS.
REQ-024 SHALL pass each gpio_in bit through a SYNC_STAGES flop chain, plus one history flop for edge detection.
REQ-025 SHALL update IN[i] from the synchroniser output only when PSL[i] & !DIR[i]; otherwise IN[i] holds its value.
REQ-026 SHALL set ISTAT[i] on a synchronised 0->1 transition when RISE_EN[i], or a 1->0 transition when FALL_EN[i], in each case only while PSL[i] & !DIR[i].
REQ-027 SHALL give a new edge priority over a same-cycle W1C clear, so the ISTAT bit stays 1.
REQ-028 SHALL apply SET and CLR writes to OUT one cycle apart from each other; SET and CLR hitting the same cycle cannot occur on APB.
REQ-029 SHALL register irq as the OR of ISTAT bits, so irq follows ISTAT by one cycle.
REQ-030 SHALL guarantee latency from a gpio_in change to a visible IN value of SYNC_STAGES cycles, and to irq of SYNC_STAGES+2 cycles.
REQ-031 SHALL NOT clear ISTAT when a pin is disabled or its DIR changes; a pending interrupt persists until cleared by W1C.

Reset
REQ-032 SHALL, while PRESETn=0, clear the FSM to IDLE and clear all registers, synchroniser and history flops; gpio_oe=0, gpio_out=0, irq=0, PRDATA=0, PREADY=0, PSLVERR=0.
REQ-033 SHALL abort any in-flight transfer on a mid-transfer reset, with no write committed.
REQ-034 SHALL raise no spurious ISTAT bit after reset release, because the history flops reset to 0 and RISE_EN/FALL_EN reset to 0.

Verification
REQ-035 SHALL cover output set/clear: write PSL=0xFF, DIR=0x0F, SET=0x05, CLR=0x01 (NPINS=8) -> gpio_oe=0x0F, gpio_out=0x04, read of 0x08 returns 0x04.
REQ-036 SHALL cover input path: PSL=0xFF, DIR=0x00, gpio_in=0xA5 -> read of 0x10 returns 0xA5 no earlier than SYNC_STAGES cycles after the change.
REQ-037 SHALL cover rising-edge interrupt: RISE_EN=0x01, gpio_in[0] 0->1 -> ISTAT=0x01, irq=1 at SYNC_STAGES+2 cycles; write ISTAT=0x01 -> irq=0 one cycle later.
REQ-038 SHALL cover the edge/clear collision: the ISTAT W1C commit and a new falling edge (FALL_EN=0x01) in the same cycle -> ISTAT[0] stays 1.
REQ-039 SHALL cover errors: write to 0x10, read 0x40, and PSEL&PENABLE from IDLE -> PSLVERR=1 with PREADY=1, and registers unchanged.
REQ-040 SHALL cover reset mid-transfer: PRESETn=0 during SETUP of a DIR=0xFF write -> DIR=0 and gpio_oe=0 after release.
